// File: rtl/wb_traffic_pkg.sv
`default_nettype none
// wb_traffic_pkg -- shared encodings for the Wishbone traffic master.
// Rev 1.0
package wb_traffic_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  typedef enum logic {
    PH_WRITE = 1'b0,
    PH_READ  = 1'b1
  } phase_t;

  localparam logic [1:0] MODE_WR_RD         = 2'd0;
  localparam logic [1:0] MODE_WR_ALL_RD_ALL = 2'd1;
  localparam logic [1:0] MODE_WR_ONLY       = 2'd2;
  localparam logic [1:0] MODE_RD_ONLY       = 2'd3;

endpackage
`default_nettype wire

// File: rtl/wb_pattern_gen.sv
`default_nettype none
// wb_pattern_gen -- registered accumulator producing seed + index*PATTERN_INC without a multiplier.
// Rev 1.0
module wb_pattern_gen
  import wb_traffic_pkg::*;
#(
  parameter int                    DATA_WIDTH  = 32,
  parameter logic [DATA_WIDTH-1:0] PATTERN_INC = DATA_WIDTH'(32'h11111111)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_load,
  input  logic                  i_reload,
  input  logic                  i_step,
  input  logic [DATA_WIDTH-1:0] i_seed,
  output logic [DATA_WIDTH-1:0] o_pattern
);

  logic [DATA_WIDTH-1:0] r_seed;
  logic [DATA_WIDTH-1:0] r_acc;

  // The seed is kept so the read phase of a write-all/read-all run can rewind to index 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_seed <= '0;
      r_acc  <= '0;
    end else if (i_load) begin
      r_seed <= i_seed;
      r_acc  <= i_seed;
    end else if (i_reload) begin
      r_acc <= r_seed;
    end else if (i_step) begin
      r_acc <= r_acc + PATTERN_INC;
    end
  end

  assign o_pattern = r_acc;

endmodule
`default_nettype wire

// File: rtl/wb_traffic_master.sv
`default_nettype none
// wb_traffic_master -- Wishbone classic-cycle master running patterned write/read traffic,
// counting slave errors, timeouts and readback mismatches without stopping. Rev 1.0
module wb_traffic_master
  import wb_traffic_pkg::*;
#(
  parameter int                    DATA_WIDTH     = 32,
  parameter int                    ADDR_WIDTH     = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDRESS   = '0,
  parameter int                    DATA_COUNT     = 16,
  parameter logic [ADDR_WIDTH-1:0] ADDR_STRIDE    = ADDR_WIDTH'(1),
  parameter logic [DATA_WIDTH-1:0] PATTERN_INC    = DATA_WIDTH'(32'h11111111),
  parameter int                    TIMEOUT_CYCLES = 255
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [1:0]                    mode,
  input  logic [DATA_WIDTH-1:0]         seed,
  output logic                          busy,
  output logic                          done,
  output logic [15:0]                   err_cnt,
  output logic [$clog2(DATA_COUNT)-1:0] first_err_idx,
  output logic                          timeout,
  output logic                          cyc_o,
  output logic                          stb_o,
  output logic                          we_o,
  output logic [ADDR_WIDTH-1:0]         adr_o,
  output logic [DATA_WIDTH-1:0]         dat_o,
  input  logic [DATA_WIDTH-1:0]         dat_i,
  input  logic                          ack_i,
  input  logic                          err_i
);

  localparam int             IDX_W    = $clog2(DATA_COUNT);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_COUNT - 1);
  localparam int             TO_W     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  localparam bit             TMO_EN   = (TIMEOUT_CYCLES != 0);

  state_t                r_state;
  state_t                w_state_nxt;
  phase_t                r_phase;
  phase_t                w_phase_nxt;
  logic                  r_start_q;
  logic [1:0]            r_mode;
  logic [IDX_W-1:0]      r_idx;
  logic [ADDR_WIDTH-1:0] r_addr_acc;
  logic [TO_W-1:0]       r_wait_cnt;
  logic [DATA_WIDTH-1:0] w_pat;

  logic w_fall;
  logic w_tmo;
  logic w_term;
  logic w_mismatch;
  logic w_err_evt;
  logic w_last;
  logic w_start_run;
  logic w_step;
  logic w_rewind;
  logic w_finish;

  assign w_fall     = !start && r_start_q;
  assign w_last     = (r_idx == LAST_IDX);
  assign w_tmo      = (r_state == S_WAIT) && !ack_i && !err_i && TMO_EN && (r_wait_cnt == TO_LAST);
  assign w_term     = ((r_state == S_WAIT) && (ack_i || err_i)) || w_tmo;
  assign w_mismatch = (r_phase == PH_READ) && ack_i && !err_i && (dat_i != w_pat);
  assign w_err_evt  = (r_state == S_WAIT) && (err_i || w_tmo || w_mismatch);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_phase_nxt = r_phase;
    w_start_run = 1'b0;
    w_step      = 1'b0;
    w_rewind    = 1'b0;
    w_finish    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_fall) begin
          w_start_run = 1'b1;
          w_state_nxt = S_REQ;
        end
      end
      S_REQ: begin
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (w_term) begin
          w_state_nxt = S_REQ;
          case (r_mode)
            MODE_WR_RD: begin
              if (r_phase == PH_WRITE) begin
                w_phase_nxt = PH_READ;
              end else if (w_last) begin
                w_finish = 1'b1;
              end else begin
                w_step      = 1'b1;
                w_phase_nxt = PH_WRITE;
              end
            end
            MODE_WR_ALL_RD_ALL: begin
              if (!w_last) begin
                w_step = 1'b1;
              end else if (r_phase == PH_WRITE) begin
                w_rewind    = 1'b1;
                w_phase_nxt = PH_READ;
              end else begin
                w_finish = 1'b1;
              end
            end
            default: begin
              if (w_last) begin
                w_finish = 1'b1;
              end else begin
                w_step = 1'b1;
              end
            end
          endcase
          if (w_finish) begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_start_q     <= 1'b0;
      r_mode        <= '0;
      r_phase       <= PH_WRITE;
      r_idx         <= '0;
      r_addr_acc    <= '0;
      r_wait_cnt    <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      err_cnt       <= '0;
      first_err_idx <= '0;
      timeout       <= 1'b0;
      cyc_o         <= 1'b0;
      stb_o         <= 1'b0;
      we_o          <= 1'b0;
      adr_o         <= '0;
      dat_o         <= '0;
    end else begin
      r_start_q <= start;

      if (w_start_run) begin
        r_mode        <= mode;
        r_phase       <= (mode == MODE_RD_ONLY) ? PH_READ : PH_WRITE;
        r_idx         <= '0;
        r_addr_acc    <= BASE_ADDRESS;
        busy          <= 1'b1;
        done          <= 1'b0;
        err_cnt       <= '0;
        first_err_idx <= '0;
        timeout       <= 1'b0;
      end else begin
        r_phase <= w_phase_nxt;
        if (w_step) begin
          r_idx      <= r_idx + IDX_W'(1);
          r_addr_acc <= r_addr_acc + ADDR_STRIDE;
        end else if (w_rewind) begin
          r_idx      <= '0;
          r_addr_acc <= BASE_ADDRESS;
        end
      end

      if (r_state == S_REQ) begin
        adr_o      <= r_addr_acc;
        we_o       <= (r_phase == PH_WRITE);
        cyc_o      <= 1'b1;
        stb_o      <= 1'b1;
        r_wait_cnt <= '0;
        if (r_phase == PH_WRITE) begin
          dat_o <= w_pat;
        end
      end else if (r_state == S_WAIT) begin
        if (w_term) begin
          cyc_o <= 1'b0;
          stb_o <= 1'b0;
          we_o  <= 1'b0;
        end else begin
          r_wait_cnt <= r_wait_cnt + TO_W'(1);
        end
      end

      // err_cnt is cleared at run start, so zero means this is the run's first error.
      if (w_err_evt) begin
        if (err_cnt != 16'hFFFF) begin
          err_cnt <= err_cnt + 16'd1;
        end
        if (err_cnt == 16'd0) begin
          first_err_idx <= r_idx;
        end
      end
      if (w_tmo) begin
        timeout <= 1'b1;
      end

      if (w_finish) begin
        busy <= 1'b0;
        done <= 1'b1;
      end
    end
  end

  wb_pattern_gen #(
    .DATA_WIDTH (DATA_WIDTH),
    .PATTERN_INC(PATTERN_INC)
  ) u_pattern_gen (
    .clk      (clk),
    .rst      (rst),
    .i_load   (w_start_run),
    .i_reload (w_rewind),
    .i_step   (w_step),
    .i_seed   (seed),
    .o_pattern(w_pat)
  );

endmodule
`default_nettype wire

// File: tb/tb_wb_traffic_master.sv
`default_nettype none
// tb_wb_traffic_master -- transaction-level model plus directed runs for the traffic master.
// Rev 1.0
module tb_wb_traffic_master;

  localparam int          N      = 16;
  localparam int          TMO    = 4;
  localparam logic [31:0] BASE   = 32'h100;
  localparam logic [31:0] STRIDE = 32'd4;
  localparam logic [31:0] INC    = 32'h11111111;
  localparam int          SL_MEM  = 0;
  localparam int          SL_ZERO = 1;
  localparam int          SL_NONE = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  mode;
  logic [31:0] seed;
  logic        busy, done, timeout, cyc_o, stb_o, we_o;
  logic [15:0] err_cnt;
  logic [3:0]  first_err_idx;
  logic [31:0] adr_o, dat_o;
  logic [31:0] dat_i = 32'h0;
  logic        ack_i = 1'b0;
  logic        err_i = 1'b0;

  always #5 clk = ~clk;

  wb_traffic_master #(
    .DATA_WIDTH    (32),
    .ADDR_WIDTH    (32),
    .BASE_ADDRESS  (BASE),
    .DATA_COUNT    (N),
    .ADDR_STRIDE   (STRIDE),
    .PATTERN_INC   (INC),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .seed(seed),
    .busy(busy), .done(done), .err_cnt(err_cnt), .first_err_idx(first_err_idx),
    .timeout(timeout), .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o),
    .adr_o(adr_o), .dat_o(dat_o), .dat_i(dat_i), .ack_i(ack_i), .err_i(err_i)
  );

  int n_checks = 0;
  int n_pass   = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, required %h", name, act, exp);
  endfunction

  function automatic logic [31:0] addr_of(input int i);
    return BASE + 32'(i) * STRIDE;
  endfunction

  function automatic logic [31:0] pat_of(input logic [31:0] s, input int i);
    return s + 32'(i) * INC;
  endfunction

  // ---------------- model ----------------
  typedef struct {
    logic we;
    int   idx;
    int   len;
  } xfer_t;

  xfer_t       exp_q[$];
  logic [31:0] shadow[N];
  int          sl_kind = SL_MEM;
  logic        inj_en  = 1'b0;
  int          inj_idx = 0;
  int          exp_err, exp_first, exp_n;
  logic        exp_tmo;
  logic [31:0] cur_seed;

  task automatic build_model(input logic [1:0] m, input logic [31:0] s);
    xfer_t order[$];
    xfer_t x;
    logic  bad;
    logic [31:0] rd;
    order.delete();
    exp_q.delete();
    exp_err = 0; exp_first = 0; exp_tmo = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (m == 2'd0) begin
        x.we = 1'b1; x.idx = i; x.len = 0; order.push_back(x);
        x.we = 1'b0; order.push_back(x);
      end else if (m != 2'd3) begin
        x.we = 1'b1; x.idx = i; x.len = 0; order.push_back(x);
      end
    end
    if (m == 2'd1 || m == 2'd3) begin
      for (int i = 0; i < N; i++) begin
        x.we = 1'b0; x.idx = i; x.len = 0; order.push_back(x);
      end
    end
    foreach (order[k]) begin
      x = order[k];
      bad = 1'b0;
      if (sl_kind == SL_NONE) begin
        bad = 1'b1; exp_tmo = 1'b1; x.len = TMO;
      end else begin
        x.len = 2;
        if (x.we) begin
          if (inj_en && x.idx == inj_idx) bad = 1'b1;
          if (sl_kind == SL_MEM) shadow[x.idx] = pat_of(s, x.idx);
        end else begin
          rd  = (sl_kind == SL_ZERO) ? 32'h0 : shadow[x.idx];
          bad = (rd != pat_of(s, x.idx));
        end
      end
      if (bad) begin
        if (exp_err == 0) exp_first = x.idx;
        exp_err++;
      end
      exp_q.push_back(x);
    end
    exp_n = order.size();
  endtask

  // ---------------- slave: one wait state, commits writes even when flagging err ----------------
  logic [31:0] smem[logic [31:0]];
  int          ws = 0;

  always @(negedge clk) begin
    if (!(cyc_o && stb_o)) begin
      ack_i = 1'b0; err_i = 1'b0; ws = 0;
    end else if (sl_kind != SL_NONE && !ack_i && !err_i) begin
      if (ws == 0) begin
        ws = 1;
      end else begin
        if (we_o && sl_kind == SL_MEM) smem[adr_o] = dat_o;
        dat_i = (sl_kind == SL_ZERO || !smem.exists(adr_o)) ? 32'h0 : smem[adr_o];
        ack_i = 1'b1;
        err_i = inj_en && we_o && (adr_o == addr_of(inj_idx));
      end
    end
  end

  // ---------------- compare process ----------------
  logic        chk_en = 1'b0;
  int          cur_len = 0;
  int          n_xfer = 0;
  logic [31:0] first_adr, last_adr;

  always @(negedge clk) begin
    if (chk_en) begin
      if (cyc_o) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected transfer: adr %h, no transfer required", adr_o);
        end else begin
          chk("xfer adr", adr_o, addr_of(exp_q[0].idx));
          chk("xfer we", 32'(we_o), 32'(exp_q[0].we));
          chk("xfer stb", 32'(stb_o), 32'd1);
          chk("busy in xfer", 32'(busy), 32'd1);
          if (exp_q[0].we) chk("xfer wdata", dat_o, pat_of(cur_seed, exp_q[0].idx));
          if (n_xfer == 0 && cur_len == 0) first_adr = adr_o;
          last_adr = adr_o;
          cur_len++;
        end
      end else if (cur_len > 0) begin
        chk("xfer cycles", cur_len, exp_q[0].len);
        void'(exp_q.pop_front());
        n_xfer++;
        cur_len = 0;
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic kick(input logic [1:0] m, input logic [31:0] s);
    build_model(m, s);
    cur_seed = s;
    n_xfer   = 0;
    mode     = m;
    seed     = s;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic finish_run(input string tag);
    bit ok = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (done) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      n_checks++;
      $display("FAIL %s run end: done never rose, required within 2000 cycles", tag);
    end
    @(negedge clk);
    chk({tag, " err_cnt"}, 32'(err_cnt), 32'(exp_err));
    chk({tag, " first_err_idx"}, 32'(first_err_idx), 32'(exp_first));
    chk({tag, " timeout"}, 32'(timeout), 32'(exp_tmo));
    chk({tag, " busy"}, 32'(busy), 32'd0);
    chk({tag, " done"}, 32'(done), 32'd1);
    chk({tag, " transfers"}, n_xfer, exp_n);
  endtask

  initial begin
    bit          found;
    logic [31:0] v;
    rst = 1'b1; start = 1'b0; mode = 2'd0; seed = 32'h0;
    foreach (shadow[i]) shadow[i] = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst err_cnt", 32'(err_cnt), 32'd0);
    chk("rst timeout", 32'(timeout), 32'd0);
    chk("rst cyc", 32'(cyc_o), 32'd0);
    chk("rst stb", 32'(stb_o), 32'd0);
    chk("rst adr", adr_o, 32'h0);
    rst = 1'b0;
    chk_en = 1'b1;
    repeat (2) @(negedge clk);

    // interleaved write/read, seed 0
    sl_kind = SL_MEM;
    kick(2'd0, 32'h0);
    finish_run("m0");
    chk("m0 err literal", 32'(err_cnt), 32'd0);
    chk("m0 xfer literal", n_xfer, 32);
    v = smem.exists(32'h13C) ? smem[32'h13C] : 32'h0;
    chk("m0 mem idx15", v, 32'hFFFFFFFF);

    // write-all then read-all
    kick(2'd1, 32'h12345678);
    finish_run("m1");
    chk("m1 first adr", first_adr, 32'h100);
    chk("m1 last adr", last_adr, 32'h13C);

    // read-only against an all-zero slave
    sl_kind = SL_ZERO;
    kick(2'd3, 32'h0);
    finish_run("m3");
    chk("m3 err literal", 32'(err_cnt), 32'd15);
    chk("m3 first literal", 32'(first_err_idx), 32'd1);

    // slave never terminates
    sl_kind = SL_NONE;
    kick(2'd2, 32'h0);
    finish_run("tmo");
    chk("tmo err literal", 32'(err_cnt), 32'd16);
    chk("tmo flag literal", 32'(timeout), 32'd1);

    // err_i together with ack_i on the index-5 write
    sl_kind = SL_MEM; inj_en = 1'b1; inj_idx = 5;
    kick(2'd0, 32'h0);
    finish_run("inj");
    chk("inj err literal", 32'(err_cnt), 32'd1);
    chk("inj first literal", 32'(first_err_idx), 32'd5);
    chk("inj xfer literal", n_xfer, 32);
    inj_en = 1'b0;

    // reset in the middle of the index-3 write
    kick(2'd0, 32'h0);
    found = 1'b0;
    for (int k = 0; k < 500; k++) begin
      @(negedge clk);
      if (cyc_o && adr_o == addr_of(3)) begin found = 1'b1; break; end
    end
    if (!found) begin
      n_checks++;
      $display("FAIL reset setup: index-3 transfer never seen, required within 500 cycles");
    end
    chk_en = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst cyc", 32'(cyc_o), 32'd0);
    chk("midrst stb", 32'(stb_o), 32'd0);
    chk("midrst busy", 32'(busy), 32'd0);
    chk("midrst done", 32'(done), 32'd0);
    chk("midrst err_cnt", 32'(err_cnt), 32'd0);
    exp_q.delete();
    cur_len = 0;
    @(negedge clk);
    chk_en = 1'b1;

    // fresh start; a second start toggle while busy must not restart the run
    kick(2'd2, 32'hA5A5A5A5);
    repeat (10) @(negedge clk);
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    finish_run("busytgl");
    chk("busytgl xfer literal", n_xfer, 16);

    kick(2'd0, 32'hA5A5A5A5);
    finish_run("m0b");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
